cmos_frame_packer: RTL and testbench
====================================

# cmos_frame_packer

Pixel-clock-domain front end for one camera channel of the dual image capture path. It takes the raw 8-bit CMOS byte stream, pairs bytes into 16-bit RGB565 pixels and packs 16 pixels into one 256-bit word. Each word is tagged with frame and line markers, and the block flags malformed lines and frames. Its output feeds the write-side FIFO of trans_cache, one instance per camera (cmos1, cmos2).

## Interface
Parameters:
- H_ACT, 1280: active pixels per line; must be a multiple of 16.
- V_ACT, 720: active lines per frame.
- LINE_W, 11: width of the line counter; requires 2^LINE_W > V_ACT.

Ports:
- cmos_pclk, in, 1: camera pixel clock; the only clock in the block.
- cmos_rst, in, 1: asynchronous, active-low reset.
- cmos_vs_in, in, 1: camera vsync, active high.
- cmos_de_in, in, 1: camera href/data enable, active high.
- cmos_data, in, 8: camera byte.
- pack_data, out, 256: packed word; pixel n occupies bits [16n+15:16n], with n=0 being the first pixel received.
- pack_valid, out, 1: one-cycle qualifier for pack_data.
- pack_sof, out, 1: high with pack_valid on the first word of a frame.
- pack_eol, out, 1: high with pack_valid on the last word of a line.
- line_cnt, out, LINE_W: index of the line currently being packed, 0-based.
- frame_done, out, 1: one-cycle pulse after line V_ACT-1 completes.
- frame_err, out, 1: one-cycle pulse on any line or frame error.

## Operation
- All inputs are registered once (stage 1). vsync and de edge detection uses the registered copies.
- FSM states: IDLE, WAIT_LINE, ACTIVE.
  - IDLE: input data is ignored until a vsync rising edge occurs. Then go to WAIT_LINE, set line_cnt=0, and arm sof.
  - WAIT_LINE: a de rising edge resets the byte phase to 0 and pixel_cnt to 0, then go to ACTIVE.
  - ACTIVE:
    - While de=1, each byte alternates phase. Phase 0 is the high byte; phase 1 completes pixel {hi,lo}.
    - Completed pixels shift into the word at slot pixel_cnt[3:0].
    - When slot 15 fills, emit the word. pack_sof is set if sof is armed (sof is then cleared). pack_eol is set if pixel_cnt==H_ACT-1.
  - ACTIVE, de falling edge:
    - If pixel_cnt != H_ACT, or the byte phase is 1: pulse frame_err. The partial word and the dangling byte are discarded and nothing is flushed.
    - In all cases line_cnt increments.
    - If the new line_cnt == V_ACT: pulse frame_done and go to IDLE. Otherwise go to WAIT_LINE.
- Pixels beyond H_ACT within one line are dropped. No word is emitted for them, and frame_err pulses once at de fall.
- A vsync rising edge in WAIT_LINE or ACTIVE before V_ACT lines completes:
  - pulse frame_err;
  - discard any partial word;
  - restart as a fresh frame (line_cnt=0, sof armed, state WAIT_LINE).
  - frame_done is not pulsed.
- A vsync rising edge in IDLE starts a frame normally.
- de is ignored while registered vsync is high.
- When de rise and de fall are detected on the same edge, the fall is processed first.

## Timing
- Reset values: pack_data=0, pack_valid=0, pack_sof=0, pack_eol=0, line_cnt=0, frame_done=0, frame_err=0. FSM=IDLE, sof cleared.
- Latency: pclk edge N samples the low byte of pixel 15 of a word. pack_valid and pack_data are registered at edge N+2 and valid for exactly one cycle.
- pack_data holds its value until the next emitted word.
- There is no backpressure. A downstream FIFO must accept one word per 32 pclk cycles sustained.
- frame_done and frame_err are registered 2 edges after the edge that samples the event (de low or vs high).
- line_cnt updates on the same edge as frame_done/frame_err.
- Reset deassertion mid-frame: the block starts in IDLE and produces no output until the next vsync rising edge.

## Test plan
Run with H_ACT=32, V_ACT=4 (2 words per line, 8 per frame).
- Nominal frame: vs pulse, then 4 lines of 64 bytes with incrementing data 0x00.. → 8 words.
  - Word0 bits[15:0]=0x0001 and bits[255:240]=0x1E1F.
  - pack_sof on word0 only; pack_eol on words 1, 3, 5, 7.
  - frame_done one cycle; frame_err never.
- Short line: line 1 carries 40 bytes (20 px) → word2 is emitted, the 4-pixel remainder is dropped, and frame_err pulses once. line_cnt still reaches 4 and frame_done pulses.
- Odd/long line: line 0 carries 65 bytes → 2 words, pack_eol on word1, frame_err once at de fall.
- Early vsync: new vs pulse after 2 lines → frame_err once, no frame_done. Next frame's word0 has pack_sof and line_cnt restarts at 0.
- Reset mid-line: cmos_rst low for 3 cycles during line 2 → all outputs return to 0 asynchronously. Bytes before the next vs produce no pack_valid, and the next full frame gives 8 correct words.
- Pre-sync garbage: de/data toggling before the first vs after reset → no pack_valid and no frame_err.

Source files
------------

// File: rtl/cmos_frame_packer.sv
// Camera byte stream to 256-bit packer: pairs bytes into RGB565 pixels, packs 16 per word,
// tags words with frame/line markers and flags malformed lines and frames.
module cmos_frame_packer #(
    parameter int H_ACT  = 1280,
    parameter int V_ACT  = 720,
    parameter int LINE_W = 11
) (
    input  logic              cmos_pclk,
    input  logic              cmos_rst,
    input  logic              cmos_vs_in,
    input  logic              cmos_de_in,
    input  logic [7:0]        cmos_data,
    output logic [255:0]      pack_data,
    output logic              pack_valid,
    output logic              pack_sof,
    output logic              pack_eol,
    output logic [LINE_W-1:0] line_cnt,
    output logic              frame_done,
    output logic              frame_err
);

    // One spare count above H_ACT so an over-long line never looks exact.
    localparam int PIX_W = $clog2(H_ACT + 2);
    localparam logic [PIX_W-1:0]  PIX_LAST = PIX_W'(H_ACT - 1);
    localparam logic [PIX_W-1:0]  PIX_END  = PIX_W'(H_ACT);
    localparam logic [PIX_W-1:0]  PIX_OVR  = PIX_W'(H_ACT + 1);
    localparam logic [LINE_W-1:0] LINE_END = LINE_W'(V_ACT);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    logic              vs_q, de_q, vs_prev_q, de_prev_q;
    logic [7:0]        data_q;
    logic [1:0]        state_q, state_d;
    logic              phase_q, phase_d;
    logic [7:0]        hi_q, hi_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic [255:0]      word_q, word_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              sof_arm_q, sof_arm_d;
    logic              emit_q, emit_d, emit_sof_q, emit_sof_d, emit_eol_q, emit_eol_d;
    logic              done_q, done_d, err_q, err_d;
    logic [255:0]      pack_data_q, pack_data_d;
    logic              pack_valid_q, pack_sof_q, pack_eol_q, frame_done_q, frame_err_q;
    logic [LINE_W-1:0] line_cnt_q;

    logic de_eff, vs_rise, de_rise, de_fall, take_byte;

    // de is masked while vsync is high; edges are taken on the masked copy.
    assign de_eff  = de_q & ~vs_q;
    assign vs_rise = vs_q & ~vs_prev_q;
    assign de_rise = de_eff & ~de_prev_q;
    assign de_fall = ~de_eff & de_prev_q;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        hi_d       = hi_q;
        pix_d      = pix_q;
        word_d     = word_q;
        line_d     = line_q;
        sof_arm_d  = sof_arm_q;
        emit_d     = 1'b0;
        emit_sof_d = 1'b0;
        emit_eol_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        take_byte  = 1'b0;
        if (vs_rise) begin
            err_d     = (state_q != ST_IDLE);
            state_d   = ST_WAIT;
            line_d    = '0;
            sof_arm_d = 1'b1;
            phase_d   = 1'b0;
            pix_d     = '0;
            word_d    = '0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (de_rise) begin
                        state_d   = ST_ACTIVE;
                        phase_d   = 1'b0;
                        pix_d     = '0;
                        take_byte = 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (de_fall) begin
                        err_d   = (pix_q != PIX_END) || phase_q;
                        line_d  = line_q + LINE_W'(1);
                        phase_d = 1'b0;
                        word_d  = '0;
                        if (line_d == LINE_END) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end else if (de_eff) begin
                        take_byte = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        // The byte that raises de is the first high byte of the line.
        if (take_byte) begin
            if (!phase_d) begin
                hi_d    = data_q;
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                if (pix_q < PIX_END) begin
                    word_d[{pix_q[3:0], 4'h0} +: 16] = {hi_q, data_q};
                    if (pix_q[3:0] == 4'hF) begin
                        emit_d     = 1'b1;
                        emit_sof_d = sof_arm_q;
                        emit_eol_d = (pix_q == PIX_LAST);
                        sof_arm_d  = 1'b0;
                    end
                end
                if (pix_q != PIX_OVR) pix_d = pix_q + PIX_W'(1);
            end
        end
    end

    assign pack_data_d = emit_q ? word_q : pack_data_q;

    always_ff @(posedge cmos_pclk or negedge cmos_rst) begin
        if (!cmos_rst) begin
            vs_q         <= 1'b0;
            de_q         <= 1'b0;
            data_q       <= '0;
            vs_prev_q    <= 1'b0;
            de_prev_q    <= 1'b0;
            state_q      <= ST_IDLE;
            phase_q      <= 1'b0;
            hi_q         <= '0;
            pix_q        <= '0;
            word_q       <= '0;
            line_q       <= '0;
            sof_arm_q    <= 1'b0;
            emit_q       <= 1'b0;
            emit_sof_q   <= 1'b0;
            emit_eol_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            pack_data_q  <= '0;
            pack_valid_q <= 1'b0;
            pack_sof_q   <= 1'b0;
            pack_eol_q   <= 1'b0;
            line_cnt_q   <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            vs_q         <= cmos_vs_in;
            de_q         <= cmos_de_in;
            data_q       <= cmos_data;
            vs_prev_q    <= vs_q;
            de_prev_q    <= de_eff;
            state_q      <= state_d;
            phase_q      <= phase_d;
            hi_q         <= hi_d;
            pix_q        <= pix_d;
            word_q       <= word_d;
            line_q       <= line_d;
            sof_arm_q    <= sof_arm_d;
            emit_q       <= emit_d;
            emit_sof_q   <= emit_sof_d;
            emit_eol_q   <= emit_eol_d;
            done_q       <= done_d;
            err_q        <= err_d;
            pack_data_q  <= pack_data_d;
            pack_valid_q <= emit_q;
            pack_sof_q   <= emit_sof_q;
            pack_eol_q   <= emit_eol_q;
            line_cnt_q   <= line_q;
            frame_done_q <= done_q;
            frame_err_q  <= err_q;
        end
    end

    assign pack_data  = pack_data_q;
    assign pack_valid = pack_valid_q;
    assign pack_sof   = pack_sof_q;
    assign pack_eol   = pack_eol_q;
    assign line_cnt   = line_cnt_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_cmos_frame_packer.sv
// Directed bench for cmos_frame_packer with H_ACT=32, V_ACT=4.
module tb_cmos_frame_packer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         vs = 1'b0;
    logic         de = 1'b0;
    logic [7:0]   data = 8'h00;
    logic [255:0] pack_data;
    logic         pack_valid, pack_sof, pack_eol, frame_done, frame_err;
    logic [10:0]  line_cnt;

    int checks = 0;
    int errors = 0;
    int n_err = 0;
    int n_done = 0;
    logic [255:0] wq[$];
    bit           sq[$];
    bit           eq[$];

    cmos_frame_packer #(.H_ACT(32), .V_ACT(4), .LINE_W(11)) dut (
        .cmos_pclk(clk), .cmos_rst(rst_n), .cmos_vs_in(vs), .cmos_de_in(de),
        .cmos_data(data), .pack_data(pack_data), .pack_valid(pack_valid),
        .pack_sof(pack_sof), .pack_eol(pack_eol), .line_cnt(line_cnt),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Recorder: collects emitted words and pulse-cycle counts for the tests to inspect.
    always @(negedge clk) begin
        if (pack_valid) begin
            wq.push_back(pack_data);
            sq.push_back(pack_sof);
            eq.push_back(pack_eol);
        end
        if (frame_err) n_err++;
        if (frame_done) n_done++;
    end

    // Expected word w of line l when line l carries bytes (l*64 + i) & 0xFF.
    function automatic logic [255:0] exp_word(int l, int w);
        logic [255:0] r;
        logic [7:0]   b;
        r = '0;
        for (int n = 0; n < 16; n++) begin
            b = 8'((l * 64 + 2 * (w * 16 + n)) & 255);
            r[16*n +: 16] = {b, b + 8'd1};
        end
        return r;
    endfunction

    task automatic clear_mon();
        wq.delete(); sq.delete(); eq.delete();
        n_err = 0; n_done = 0;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            de = 1'b0; vs = 1'b0;
        end
    endtask

    task automatic vs_pulse();
        @(negedge clk); de = 1'b0; vs = 1'b1;
        @(negedge clk);
        @(negedge clk); vs = 1'b0;
        idle(4);
    endtask

    task automatic send_line(int nbytes, int start);
        for (int i = 0; i < nbytes; i++) begin
            @(negedge clk);
            de = 1'b1; data = 8'((start + i) & 255);
        end
        idle(6);
    endtask

    task automatic apply_reset();
        @(negedge clk); rst_n = 1'b0; de = 1'b0; vs = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(3);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({pack_data, pack_valid, pack_sof, pack_eol, line_cnt, frame_done, frame_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b sof=%b eol=%b line=%0d done=%b err=%b data=%h exp all zero",
                     pack_valid, pack_sof, pack_eol, line_cnt, frame_done, frame_err, pack_data);
        end
        rst_n = 1'b1;
        idle(3);
    endtask

    task automatic test_garbage();
        clear_mon();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            de = (i % 7) < 5; data = 8'(i * 13);
        end
        idle(6);
        checks++;
        if (wq.size() != 0) begin errors++; $display("FAIL garbage_words got %0d exp 0", wq.size()); end
        checks++;
        if (n_err != 0) begin errors++; $display("FAIL garbage_err got %0d exp 0", n_err); end
    endtask

    task automatic test_latency();
        clear_mon();
        vs_pulse();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            de = 1'b1; data = 8'(i);
        end
        @(negedge clk); de = 1'b0;
        checks++;
        if (pack_valid !== 1'b0) begin errors++; $display("FAIL lat_n0 got %b exp 0", pack_valid); end
        @(negedge clk);
        checks++;
        if (pack_valid !== 1'b0) begin errors++; $display("FAIL lat_n1 got %b exp 0", pack_valid); end
        @(negedge clk);
        checks++;
        if (pack_valid !== 1'b1 || pack_sof !== 1'b1 || pack_data !== exp_word(0, 0)) begin
            errors++;
            $display("FAIL lat_n2 got valid=%b sof=%b data=%h exp 1 1 %h", pack_valid, pack_sof, pack_data, exp_word(0, 0));
        end
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL lat_err_early got %b exp 0", frame_err); end
        @(negedge clk);
        checks++;
        if (pack_valid !== 1'b0 || frame_err !== 1'b1 || line_cnt !== 11'd1) begin
            errors++;
            $display("FAIL lat_n3 got valid=%b err=%b line=%0d exp 0 1 1", pack_valid, frame_err, line_cnt);
        end
        @(negedge clk);
        checks++;
        if (frame_err !== 1'b0 || pack_data !== exp_word(0, 0)) begin
            errors++;
            $display("FAIL lat_hold got err=%b data=%h exp 0 %h", frame_err, pack_data, exp_word(0, 0));
        end
        apply_reset();
    endtask

    task automatic test_nominal();
        clear_mon();
        vs_pulse();
        for (int l = 0; l < 4; l++) send_line(64, l * 64);
        checks++;
        if (wq.size() != 8) begin errors++; $display("FAIL nom_count got %0d exp 8", wq.size()); end
        for (int w = 0; w < 8 && w < wq.size(); w++) begin
            checks++;
            if (wq[w] !== exp_word(w / 2, w % 2)) begin
                errors++; $display("FAIL nom_word%0d got %h exp %h", w, wq[w], exp_word(w / 2, w % 2));
            end
            checks++;
            if (sq[w] !== (w == 0) || eq[w] !== (w % 2 == 1)) begin
                errors++; $display("FAIL nom_flags%0d got sof=%b eol=%b exp %b %b", w, sq[w], eq[w], w == 0, w % 2 == 1);
            end
        end
        if (wq.size() > 0) begin
            checks++;
            if (wq[0][15:0] !== 16'h0001 || wq[0][255:240] !== 16'h1E1F) begin
                errors++; $display("FAIL nom_ends got %h %h exp 0001 1e1f", wq[0][15:0], wq[0][255:240]);
            end
        end
        checks++;
        if (n_done != 1 || n_err != 0) begin errors++; $display("FAIL nom_pulses got done=%0d err=%0d exp 1 0", n_done, n_err); end
        checks++;
        if (line_cnt !== 11'd4) begin errors++; $display("FAIL nom_line got %0d exp 4", line_cnt); end
    endtask

    task automatic test_short_line();
        clear_mon();
        vs_pulse();
        send_line(64, 0);
        send_line(40, 64);
        send_line(64, 128);
        send_line(64, 192);
        checks++;
        if (wq.size() != 7) begin errors++; $display("FAIL short_count got %0d exp 7", wq.size()); end
        if (wq.size() > 2) begin
            checks++;
            if (wq[2] !== exp_word(1, 0) || eq[2] !== 1'b0) begin
                errors++; $display("FAIL short_word2 got %h eol=%b exp %h 0", wq[2], eq[2], exp_word(1, 0));
            end
        end
        if (wq.size() > 3) begin
            checks++;
            if (wq[3] !== exp_word(2, 0)) begin errors++; $display("FAIL short_word3 got %h exp %h", wq[3], exp_word(2, 0)); end
        end
        checks++;
        if (n_err != 1 || n_done != 1 || line_cnt !== 11'd4) begin
            errors++; $display("FAIL short_pulses got err=%0d done=%0d line=%0d exp 1 1 4", n_err, n_done, line_cnt);
        end
    endtask

    task automatic test_long_line();
        clear_mon();
        vs_pulse();
        send_line(65, 0);
        checks++;
        if (wq.size() != 2 || n_err != 1) begin
            errors++; $display("FAIL long_line0 got words=%0d err=%0d exp 2 1", wq.size(), n_err);
        end
        if (wq.size() > 1) begin
            checks++;
            if (wq[1] !== exp_word(0, 1) || eq[1] !== 1'b1 || eq[0] !== 1'b0) begin
                errors++; $display("FAIL long_word1 got %h eol=%b%b exp %h 10", wq[1], eq[1], eq[0], exp_word(0, 1));
            end
        end
        for (int l = 1; l < 4; l++) send_line(64, l * 64);
        checks++;
        if (wq.size() != 8 || n_err != 1 || n_done != 1) begin
            errors++; $display("FAIL long_frame got words=%0d err=%0d done=%0d exp 8 1 1", wq.size(), n_err, n_done);
        end
    endtask

    task automatic test_early_vs();
        clear_mon();
        vs_pulse();
        send_line(64, 0);
        send_line(64, 64);
        vs_pulse();
        checks++;
        if (n_err != 1 || n_done != 0 || wq.size() != 4) begin
            errors++; $display("FAIL early_pulses got err=%0d done=%0d words=%0d exp 1 0 4", n_err, n_done, wq.size());
        end
        checks++;
        if (line_cnt !== 11'd0) begin errors++; $display("FAIL early_line got %0d exp 0", line_cnt); end
        clear_mon();
        for (int l = 0; l < 4; l++) send_line(64, l * 64);
        checks++;
        if (wq.size() != 8 || n_done != 1 || n_err != 0) begin
            errors++; $display("FAIL early_next got words=%0d done=%0d err=%0d exp 8 1 0", wq.size(), n_done, n_err);
        end
        if (wq.size() > 1) begin
            checks++;
            if (sq[0] !== 1'b1 || sq[1] !== 1'b0 || wq[0] !== exp_word(0, 0)) begin
                errors++; $display("FAIL early_sof got sof=%b%b word0=%h exp 1 0 %h", sq[0], sq[1], wq[0], exp_word(0, 0));
            end
        end
    endtask

    task automatic test_reset_midline();
        vs_pulse();
        send_line(64, 0);
        send_line(64, 64);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            de = 1'b1; data = 8'(128 + i);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({pack_data, pack_valid, pack_sof, pack_eol, line_cnt, frame_done, frame_err} !== '0) begin
            errors++; $display("FAIL midrst_async got line=%0d data=%h exp all zero", line_cnt, pack_data);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        for (int i = 20; i < 64; i++) begin
            @(negedge clk);
            de = 1'b1; data = 8'(128 + i);
        end
        idle(6);
        send_line(64, 192);
        checks++;
        if (wq.size() != 0 || n_err != 0 || n_done != 0) begin
            errors++; $display("FAIL midrst_quiet got words=%0d err=%0d done=%0d exp 0 0 0", wq.size(), n_err, n_done);
        end
        clear_mon();
        vs_pulse();
        for (int l = 0; l < 4; l++) send_line(64, l * 64);
        checks++;
        if (wq.size() != 8 || n_done != 1 || n_err != 0) begin
            errors++; $display("FAIL midrst_frame got words=%0d done=%0d err=%0d exp 8 1 0", wq.size(), n_done, n_err);
        end
        for (int w = 0; w < 8 && w < wq.size(); w++) begin
            checks++;
            if (wq[w] !== exp_word(w / 2, w % 2) || sq[w] !== (w == 0) || eq[w] !== (w % 2 == 1)) begin
                errors++; $display("FAIL midrst_word%0d got %h sof=%b eol=%b exp %h", w, wq[w], sq[w], eq[w], exp_word(w / 2, w % 2));
            end
        end
    endtask

    initial begin
        test_reset();
        test_garbage();
        test_latency();
        test_nominal();
        test_short_line();
        test_long_line();
        test_early_vs();
        test_reset_midline();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
